// File: rtl/hilbert_pkg.sv
// hilbert_pkg: shared constants, coefficient table, FSM state type and the
// output round/saturate helper for the time-multiplexed Hilbert FIR.
//   HILB_DATA_W / HILB_COEF_W / HILB_TAPS : default widths and filter length
//   HILB_P / HILB_C / HILB_ACC_W          : derived pair count, centre, acc width
//   HILB_COEF                             : positive half of the odd taps, Q1.15
//   state_e                               : IDLE / MAC / OUT
//   round_sat()                           : acc -> output sample
package hilbert_pkg;

   localparam int unsigned HILB_DATA_W = 16;
   localparam int unsigned HILB_COEF_W = 16;
   localparam int unsigned HILB_TAPS   = 31;
   localparam int unsigned HILB_P      = (HILB_TAPS + 1) / 4;
   localparam int unsigned HILB_C      = (HILB_TAPS - 1) / 2;
   localparam int unsigned HILB_ACC_W  = HILB_DATA_W + 1 + HILB_COEF_W + $clog2(HILB_P);

   // coef(d) for d = 1,3,...,15: Hamming-windowed 2/(pi*d), rounded to Q1.15
   localparam logic signed [HILB_COEF_W-1:0] HILB_COEF [HILB_P] = '{
      16'sd20651, 16'sd6343, 16'sd3213, 16'sd1753,
      16'sd922,   16'sd440,  16'sd192,  16'sd111
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      OUT  = 2'd2
   } state_e;

   localparam logic signed [HILB_ACC_W:0] ROUND_BIAS = (HILB_ACC_W + 1)'(2 ** (HILB_COEF_W - 2));
   localparam logic signed [HILB_ACC_W:0] SAT_MAX    = (HILB_ACC_W + 1)'(2 ** (HILB_DATA_W - 1) - 1);
   localparam logic signed [HILB_ACC_W:0] SAT_MIN    = -SAT_MAX - 1;

   // Round half up, drop the Q1.15 fraction, clamp to the output range.
   // One guard bit above the accumulator keeps the bias add from wrapping.
   function automatic logic signed [HILB_DATA_W-1:0] round_sat(
      input logic signed [HILB_ACC_W-1:0] acc
   );
      logic signed [HILB_ACC_W:0] biased;
      logic signed [HILB_ACC_W:0] shifted;
      biased  = (HILB_ACC_W + 1)'(acc) + ROUND_BIAS;
      shifted = biased >>> (HILB_COEF_W - 1);
      if (shifted > SAT_MAX) begin
         return SAT_MAX[HILB_DATA_W-1:0];
      end else if (shifted < SAT_MIN) begin
         return SAT_MIN[HILB_DATA_W-1:0];
      end else begin
         return shifted[HILB_DATA_W-1:0];
      end
   endfunction

endpackage

// File: rtl/hilbert_sample_buf.sv
// hilbert_sample_buf: TAPS-entry circular sample history with synchronous clear.
//   clk, clr          : clock, synchronous clear (entries and write pointer)
//   wr_en, wr_data    : push one sample as the new newest entry
//   rd_off_a/b        : offsets from newest (0 = newest) for the two tap reads
//   rd_data_a/b       : combinational read data for those offsets
//   rd_data_c         : combinational read at the fixed centre offset C
module hilbert_sample_buf
   import hilbert_pkg::*;
#(
   parameter int unsigned DATA_W = HILB_DATA_W,
   parameter int unsigned TAPS   = HILB_TAPS,
   parameter int unsigned OFF_W  = $clog2(TAPS)
)(
   input  logic              clk,
   input  logic              clr,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [OFF_W-1:0]  rd_off_a,
   input  logic [OFF_W-1:0]  rd_off_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   output logic [DATA_W-1:0] rd_data_c
);

   localparam int unsigned C = (TAPS - 1) / 2;

   logic [DATA_W-1:0] mem_q [TAPS];
   logic [DATA_W-1:0] mem_d [TAPS];
   logic [OFF_W-1:0]  wp_q;
   logic [OFF_W-1:0]  wp_d;

   // Newest entry sits at wp-1, so offset k lives at (wp + TAPS-1 - k) mod TAPS.
   // The sum stays below 2*TAPS, so a single conditional subtract suffices.
   function automatic logic [OFF_W-1:0] addr_of(
      input logic [OFF_W-1:0] wp,
      input logic [OFF_W-1:0] off
   );
      logic [OFF_W:0] sum;
      sum = {1'b0, wp} + (OFF_W + 1)'(TAPS - 1) - {1'b0, off};
      if (sum >= (OFF_W + 1)'(TAPS)) begin
         sum = sum - (OFF_W + 1)'(TAPS);
      end
      return sum[OFF_W-1:0];
   endfunction

   always_comb begin
      mem_d = mem_q;
      wp_d  = wp_q;
      if (wr_en) begin
         mem_d[wp_q] = wr_data;
         wp_d        = (wp_q == OFF_W'(TAPS - 1)) ? '0 : wp_q + OFF_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         mem_q <= '{default: '0};
         wp_q  <= '0;
      end else begin
         mem_q <= mem_d;
         wp_q  <= wp_d;
      end
   end

   assign rd_data_a = mem_q[addr_of(wp_q, rd_off_a)];
   assign rd_data_b = mem_q[addr_of(wp_q, rd_off_b)];
   assign rd_data_c = mem_q[addr_of(wp_q, OFF_W'(C))];

endmodule

// File: rtl/hilbert_fir_core.sv
// hilbert_fir_core: single-multiplier Type-III Hilbert FIR, one sample per
// P+2 cycles. Each accepted sample runs P pre-subtract/MAC cycles followed by
// an output cycle that rounds, saturates and registers the result.
//   clk, RST            : clock, synchronous active-high reset
//   in_data, in_valid   : input sample and its valid
//   in_ready            : high while idle; a transfer is in_valid & in_ready
//   q_data              : quadrature (Hilbert) output, held until next strobe
//   i_data              : input delayed by C samples, held until next strobe
//   out_valid           : one-cycle strobe marking a new q_data/i_data pair
module hilbert_fir_core
   import hilbert_pkg::*;
#(
   parameter int unsigned DATA_W = HILB_DATA_W,
   parameter int unsigned COEF_W = HILB_COEF_W,
   parameter int unsigned TAPS   = HILB_TAPS
)(
   input  logic              clk,
   input  logic              RST,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] q_data,
   output logic [DATA_W-1:0] i_data,
   output logic              out_valid
);

   localparam int unsigned P      = (TAPS + 1) / 4;
   localparam int unsigned C      = (TAPS - 1) / 2;
   localparam int unsigned J_W    = (P > 1) ? $clog2(P) : 1;
   localparam int unsigned OFF_W  = $clog2(TAPS);
   localparam int unsigned PROD_W = DATA_W + 1 + COEF_W;
   localparam int unsigned ACC_W  = DATA_W + 1 + COEF_W + $clog2(P);
   localparam logic [J_W-1:0] LAST_J = J_W'(P - 1);

   state_e                    state_q, state_d;
   logic [J_W-1:0]            j_q, j_d;
   logic signed [ACC_W-1:0]   acc_q, acc_d;
   logic [DATA_W-1:0]         q_data_q, q_data_d;
   logic [DATA_W-1:0]         i_data_q, i_data_d;
   logic                      out_valid_q, out_valid_d;

   logic                      wr_en;
   logic [OFF_W-1:0]          off_a, off_b;
   logic [DATA_W-1:0]         rd_a, rd_b, rd_c;
   logic signed [DATA_W:0]    diff;
   logic signed [PROD_W-1:0]  prod;

   hilbert_sample_buf #(
      .DATA_W (DATA_W),
      .TAPS   (TAPS),
      .OFF_W  (OFF_W)
   ) u_buf (
      .clk       (clk),
      .clr       (RST),
      .wr_en     (wr_en),
      .wr_data   (in_data),
      .rd_off_a  (off_a),
      .rd_off_b  (off_b),
      .rd_data_a (rd_a),
      .rd_data_b (rd_b),
      .rd_data_c (rd_c)
   );

   // Pair j uses d = 2j+1: offset C-d is the newer (+coef) tap, C+d the older (-coef) tap.
   always_comb begin
      off_a = OFF_W'(C - 1) - OFF_W'({j_q, 1'b0});
      off_b = OFF_W'(C + 1) + OFF_W'({j_q, 1'b0});
      diff  = $signed({rd_a[DATA_W-1], rd_a}) - $signed({rd_b[DATA_W-1], rd_b});
      prod  = PROD_W'(diff) * PROD_W'(HILB_COEF[j_q]);
   end

   // State register
   always_ff @(posedge clk) begin
      if (RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)       state_d = MAC;
         MAC:     if (j_q == LAST_J)  state_d = OUT;
         OUT:                         state_d = IDLE;
         default:                     state_d = IDLE;
      endcase
   end

   // Output / datapath logic
   always_comb begin
      in_ready    = 1'b0;
      wr_en       = 1'b0;
      j_d         = j_q;
      acc_d       = acc_q;
      q_data_d    = q_data_q;
      i_data_d    = i_data_q;
      out_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               wr_en = 1'b1;
               j_d   = '0;
               acc_d = '0;
            end
         end
         MAC: begin
            acc_d = acc_q + ACC_W'(prod);
            j_d   = (j_q == LAST_J) ? '0 : j_q + J_W'(1);
         end
         OUT: begin
            q_data_d    = round_sat(acc_q);
            i_data_d    = rd_c;
            out_valid_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         j_q         <= '0;
         acc_q       <= '0;
         q_data_q    <= '0;
         i_data_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         j_q         <= j_d;
         acc_q       <= acc_d;
         q_data_q    <= q_data_d;
         i_data_q    <= i_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign q_data    = q_data_q;
   assign i_data    = i_data_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_hilbert_fir_core.sv
// Directed bench for hilbert_fir_core with hand-computed expectations.
module tb_hilbert_fir_core;

   localparam int DATA_W  = 16;
   localparam int COEF_W  = 16;
   localparam int TAPS    = 31;
   localparam int P       = 8;
   localparam int EXP_LAT = P + 1;   // strobe follows the edge P+1 after the accept edge
   localparam int TIMEOUT = 20;

   // Impulse of 16384 at offset k: round_half_up(16384*h[k]/2^15)
   localparam int IMP_Q [31] = '{
      56, 0, 96, 0, 220, 0, 461, 0, 877, 0, 1607, 0, 3172, 0, 10326, 0,
      -10325, 0, -3171, 0, -1606, 0, -876, 0, -461, 0, -220, 0, -96, 0, -55
   };
   // Impulse of 500 at offset k, k = 0..15
   localparam int IMP500_Q [16] = '{
      2, 0, 3, 0, 7, 0, 14, 0, 27, 0, 49, 0, 97, 0, 315, 0
   };

   logic              clk = 1'b0;
   logic              RST;
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] q_data;
   logic [DATA_W-1:0] i_data;
   logic              out_valid;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hilbert_fir_core #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .TAPS   (TAPS)
   ) dut (
      .clk       (clk),
      .RST       (RST),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .q_data    (q_data),
      .i_data    (i_data),
      .out_valid (out_valid)
   );

   task automatic apply_reset(input int cycles);
      RST = 1'b1;
      repeat (cycles) begin
         @(posedge clk); #1;
      end
      RST = 1'b0;
   endtask

   // Push one sample and wait (bounded) for its strobe; lat = -1 on timeout.
   task automatic feed(input int v, output logic signed [15:0] q,
                       output logic signed [15:0] i, output int lat);
      in_data  = 16'(v);
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = '0;
      lat = -1;
      q   = '0;
      i   = '0;
      for (int k = 1; k <= TIMEOUT; k++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            lat = k;
            q   = $signed(q_data);
            i   = $signed(i_data);
            break;
         end
      end
   endtask

   task automatic test_reset();
      in_valid = 1'b0;
      in_data  = '0;
      apply_reset(3);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      checks++; if (q_data !== 16'd0) begin errors++; $display("FAIL reset_q got %0d want 0", q_data); end
      checks++; if (i_data !== 16'd0) begin errors++; $display("FAIL reset_i got %0d want 0", i_data); end
   endtask

   task automatic test_latency();
      int low_cnt = 0;
      int strobes = 0;
      int first   = -1;
      logic ready_at_strobe = 1'b0;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_ready_before got %b want 1", in_ready); end
      in_data  = 16'd100;
      in_valid = 1'b1;
      for (int e = 0; e <= 14; e++) begin
         @(posedge clk); #1;
         in_valid = 1'b0;
         if (e <= 8 && in_ready === 1'b0) low_cnt++;
         if (out_valid === 1'b1) begin
            strobes++;
            if (first < 0) begin
               first = e;
               ready_at_strobe = in_ready;
            end
         end
      end
      checks++; if (low_cnt !== 9) begin errors++; $display("FAIL lat_busy_cycles got %0d want 9", low_cnt); end
      checks++; if (strobes !== 1) begin errors++; $display("FAIL lat_strobe_count got %0d want 1", strobes); end
      checks++; if (first !== EXP_LAT) begin errors++; $display("FAIL lat_strobe_edge got %0d want %0d", first, EXP_LAT); end
      checks++; if (ready_at_strobe !== 1'b1) begin errors++; $display("FAIL lat_ready_at_strobe got %b want 1", ready_at_strobe); end
      checks++; if (q_data !== 16'd0) begin errors++; $display("FAIL lat_q got %0d want 0", q_data); end
      checks++; if (i_data !== 16'd0) begin errors++; $display("FAIL lat_i got %0d want 0", i_data); end
   endtask

   task automatic test_dc();
      logic signed [15:0] q, i;
      int lat;
      for (int n = 0; n < 34; n++) begin
         feed(1000, q, i, lat);
         if (n >= 30) begin
            checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL dc_lat n=%0d got %0d want %0d", n, lat, EXP_LAT); end
            checks++; if (q !== 16'sd0) begin errors++; $display("FAIL dc_q n=%0d got %0d want 0", n, q); end
            checks++; if (i !== 16'sd1000) begin errors++; $display("FAIL dc_i n=%0d got %0d want 1000", n, i); end
         end
      end
   endtask

   task automatic test_impulse();
      logic signed [15:0] q, i;
      int lat;
      int exp_i;
      apply_reset(2);
      for (int k = 0; k < 31; k++) begin
         feed((k == 0) ? 16384 : 0, q, i, lat);
         exp_i = (k == 15) ? 16384 : 0;
         checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL imp_lat k=%0d got %0d want %0d", k, lat, EXP_LAT); end
         checks++; if (int'(q) !== IMP_Q[k]) begin errors++; $display("FAIL imp_q k=%0d got %0d want %0d", k, q, IMP_Q[k]); end
         checks++; if (int'(i) !== exp_i) begin errors++; $display("FAIL imp_i k=%0d got %0d want %0d", k, i, exp_i); end
      end
   endtask

   task automatic test_saturation();
      logic signed [15:0] q, i;
      int lat;
      int k;
      int v;
      int exp_q;
      for (int pass = 0; pass < 2; pass++) begin
         for (int s = 0; s < 31; s++) begin
            k = 30 - s;   // offset of this sample once all 31 are in
            if (k % 2 == 0 && k < 15) v = 32767;
            else if (k % 2 == 0 && k > 15) v = -32767;
            else v = 0;
            if (pass == 1) v = -v;
            feed(v, q, i, lat);
         end
         exp_q = (pass == 0) ? 32767 : -32768;
         checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL sat_lat pass=%0d got %0d want %0d", pass, lat, EXP_LAT); end
         checks++; if (int'(q) !== exp_q) begin errors++; $display("FAIL sat_q pass=%0d got %0d want %0d", pass, q, exp_q); end
         checks++; if (i !== 16'sd0) begin errors++; $display("FAIL sat_i pass=%0d got %0d want 0", pass, i); end
      end
   endtask

   task automatic test_back_to_back();
      int cnt;
      int m = 0;
      int last_e = -1;
      int exp_i;
      int exp_gap;
      apply_reset(2);
      cnt      = 1;
      in_data  = 16'(cnt);
      in_valid = 1'b1;
      for (int e = 0; e < 200; e++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) begin
            exp_i   = (m >= 15) ? (10 * m - 149) : 0;
            exp_gap = (m == 0) ? EXP_LAT : P + 2;
            checks++; if ($signed(i_data) !== 16'(exp_i)) begin errors++; $display("FAIL b2b_i m=%0d got %0d want %0d", m, $signed(i_data), exp_i); end
            checks++; if (e - last_e - ((m == 0) ? 1 : 0) !== exp_gap) begin errors++; $display("FAIL b2b_gap m=%0d got %0d want %0d", m, e - last_e, exp_gap); end
            last_e = e;
            m++;
         end
         cnt++;
         in_data = 16'(cnt);
      end
      in_valid = 1'b0;
      in_data  = '0;
      checks++; if (m !== 20) begin errors++; $display("FAIL b2b_strobes got %0d want 20", m); end
   endtask

   task automatic test_reset_mid_mac();
      logic signed [15:0] q, i;
      int lat;
      int strobes = 0;
      int exp_i;
      in_data  = 16'd7000;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      RST = 1'b1;
      @(posedge clk); #1;
      RST = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready got %b want 1", in_ready); end
      checks++; if (q_data !== 16'd0) begin errors++; $display("FAIL abort_q got %0d want 0", q_data); end
      checks++; if (i_data !== 16'd0) begin errors++; $display("FAIL abort_i got %0d want 0", i_data); end
      repeat (12) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) strobes++;
      end
      checks++; if (strobes !== 0) begin errors++; $display("FAIL abort_strobes got %0d want 0", strobes); end
      for (int k = 0; k < 16; k++) begin
         feed((k == 0) ? 500 : 0, q, i, lat);
         exp_i = (k == 15) ? 500 : 0;
         checks++; if (lat !== EXP_LAT) begin errors++; $display("FAIL cold_lat k=%0d got %0d want %0d", k, lat, EXP_LAT); end
         checks++; if (int'(q) !== IMP500_Q[k]) begin errors++; $display("FAIL cold_q k=%0d got %0d want %0d", k, q, IMP500_Q[k]); end
         checks++; if (int'(i) !== exp_i) begin errors++; $display("FAIL cold_i k=%0d got %0d want %0d", k, i, exp_i); end
      end
   endtask

   initial begin
      RST      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      test_reset();
      test_latency();
      test_dc();
      test_impulse();
      test_saturation();
      test_back_to_back();
      test_reset_mid_mac();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
